branch_commit: RTL

BRANCH_COMMIT -- requirements
Module: branch_commit

---
 rtl/branch_commit_pkg.sv | 24 ++
 rtl/branch_commit_if.sv | 40 ++++
 rtl/branch_commit_bq_fifo.sv | 55 +++++
 rtl/branch_commit.sv | 86 ++++++++
 4 files changed

// File: rtl/branch_commit_pkg.sv
// Shared types for the branch commit path: field widths, the queued-branch
// record, and the helpers that decide whether a branch was mispredicted.
package branch_commit_pkg;

    localparam int PATTERN_WIDTH  = 8;
    localparam int INST_MEM_WIDTH = 12;

    typedef struct packed {
        logic [PATTERN_WIDTH-1:0]  pattern;
        logic [1:0]                prediction;
        logic [INST_MEM_WIDTH-1:0] target;
        logic [INST_MEM_WIDTH-1:0] fallthrough;
    } bq_entry_t;

    // The predicted direction is the MSB of the 2-bit saturating counter.
    function automatic logic is_mispredict(input logic [1:0] prediction, input logic taken);
        return prediction[1] != taken;
    endfunction

    function automatic logic [INST_MEM_WIDTH-1:0] redirect_addr(input bq_entry_t e, input logic taken);
        return taken ? e.target : e.fallthrough;
    endfunction

endpackage

// File: rtl/branch_commit_if.sv
// Fetch/execute-facing bundle of the branch commit unit.
// The master side is fetch+execute; the slave side is branch_commit.
interface branch_commit_if #(parameter int DEPTH = 4);
    import branch_commit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic                      issue_b;
    logic [PATTERN_WIDTH-1:0]  pattern_in;
    logic [1:0]                prediction_in;
    logic [INST_MEM_WIDTH-1:0] target_in;
    logic [INST_MEM_WIDTH-1:0] fallthrough_in;
    logic                      resolve;
    logic                      resolve_taken;

    logic                      full;
    logic [CW-1:0]             count;
    logic                      commit_b;
    logic [PATTERN_WIDTH-1:0]  pattern_end;
    logic [1:0]                prediction_end;
    logic                      failure;
    logic                      flush;
    logic [INST_MEM_WIDTH-1:0] addr_on_failure;
    logic                      err;

    modport master (
        output issue_b, pattern_in, prediction_in, target_in, fallthrough_in,
               resolve, resolve_taken,
        input  full, count, commit_b, pattern_end, prediction_end, failure,
               flush, addr_on_failure, err
    );

    modport slave (
        input  issue_b, pattern_in, prediction_in, target_in, fallthrough_in,
               resolve, resolve_taken,
        output full, count, commit_b, pattern_end, prediction_end, failure,
               flush, addr_on_failure, err
    );

endinterface

// File: rtl/branch_commit_bq_fifo.sv
// In-order branch queue: DEPTH-entry distributed-RAM FIFO with a clear-all
// input that empties it in one cycle (clear also swallows a same-cycle push).
module bq_fifo
    import branch_commit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  bq_entry_t     i_wdata,
    output bq_entry_t     o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    bq_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    // A simultaneous pop frees the slot, so a full queue still accepts the push.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/branch_commit.sv
// Branch commit unit: queues fetched conditional branches, retires them in
// order on resolve, and raises commit/flush strobes for the predictor and fetch.
module branch_commit
    import branch_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_commit_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    bq_entry_t     w_entry;
    bq_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_resolve_ok;
    logic          w_mispredict;
    logic          w_proto_err;

    logic                      r_commit;
    logic                      r_failure;
    logic                      r_flush;
    logic                      r_err;
    logic [PATTERN_WIDTH-1:0]  r_pattern_end;
    logic [1:0]                r_prediction_end;
    logic [INST_MEM_WIDTH-1:0] r_addr_on_failure;

    assign w_entry = '{pattern:     bus.pattern_in,
                       prediction:  bus.prediction_in,
                       target:      bus.target_in,
                       fallthrough: bus.fallthrough_in};

    // Resolve sees the queue as it was before this cycle's issue.
    assign w_resolve_ok = bus.resolve && (w_count != '0);
    assign w_mispredict = w_resolve_ok && is_mispredict(w_head.prediction, bus.resolve_taken);
    assign w_proto_err  = (bus.resolve && (w_count == '0)) ||
                          (bus.issue_b && w_full && !w_resolve_ok);

    bq_fifo #(.DEPTH(DEPTH)) u_bq_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_mispredict),
        .i_push  (bus.issue_b),
        .i_pop   (w_resolve_ok),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commit          <= 1'b0;
            r_failure         <= 1'b0;
            r_flush           <= 1'b0;
            r_err             <= 1'b0;
            r_pattern_end     <= '0;
            r_prediction_end  <= '0;
            r_addr_on_failure <= '0;
        end else begin
            r_commit  <= w_resolve_ok;
            r_failure <= w_mispredict;
            r_flush   <= w_mispredict;
            if (w_proto_err) r_err <= 1'b1;
            if (w_resolve_ok) begin
                r_pattern_end    <= w_head.pattern;
                r_prediction_end <= w_head.prediction;
            end
            if (w_mispredict) r_addr_on_failure <= redirect_addr(w_head, bus.resolve_taken);
        end
    end

    assign bus.full            = w_full;
    assign bus.count           = w_count;
    assign bus.commit_b        = r_commit;
    assign bus.failure         = r_failure;
    assign bus.flush           = r_flush;
    assign bus.err             = r_err;
    assign bus.pattern_end     = r_pattern_end;
    assign bus.prediction_end  = r_prediction_end;
    assign bus.addr_on_failure = r_addr_on_failure;

endmodule
